// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command sequencer: sends a command (plus optional argument byte),
// handles ACK/RESEND/ERROR replies, collects response bytes and forwards unsolicited bytes.
module ps2_cmd_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 320000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  input  logic [1:0] cmd_nresp,
  output logic       done,
  output logic [1:0] status,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       key_valid,
  output logic [7:0] key_data,
  output logic       tx_ena,
  output logic [7:0] tx_data,
  input  logic       tx_active,
  input  logic       tx_err,
  input  logic       rx_valid,
  input  logic [7:0] rx_data
);

  localparam int unsigned RW_RAW = $clog2(MAX_RETRY + 1);
  localparam int unsigned RW     = (RW_RAW < 2) ? 2 : RW_RAW;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [18:0]   TMO_LOAD  = 19'(ACK_TIMEOUT - 1);

  localparam logic [7:0] DEV_ACK    = 8'hFA;
  localparam logic [7:0] DEV_RESEND = 8'hFE;
  localparam logic [7:0] DEV_ERROR  = 8'hFC;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEND = 3'd1,
    TXG  = 3'd2,
    TXW  = 3'd3,
    WACK = 3'd4,
    WRSP = 3'd5,
    FIN  = 3'd6
  } state_e;

  typedef enum logic {
    PH_CMD = 1'b0,
    PH_ARG = 1'b1
  } phase_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_TIMEOUT = 2'd1,
    ST_NAK     = 2'd2,
    ST_TXERR   = 2'd3
  } status_e;

  state_e         state_q, state_d;
  phase_e         phase_q, phase_d;
  status_e        status_q, status_d;
  logic [18:0]    timer_q, timer_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic [7:0]     cmd_q, cmd_d;
  logic [7:0]     arg_q, arg_d;
  logic           has_arg_q, has_arg_d;
  logic [1:0]     nresp_q, nresp_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic           resp_valid_q, resp_valid_d;
  logic [7:0]     resp_data_q, resp_data_d;
  logic           key_valid_q, key_valid_d;
  logic [7:0]     key_data_q, key_data_d;

  assign cmd_ready  = (state_q == IDLE);
  assign tx_ena     = (state_q == SEND);
  assign done       = (state_q == FIN);
  assign status     = status_q;
  assign tx_data    = tx_data_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign key_valid  = key_valid_q;
  assign key_data   = key_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= PH_CMD;
      status_q     <= ST_OK;
      timer_q      <= '0;
      retry_q      <= '0;
      cmd_q        <= '0;
      arg_q        <= '0;
      has_arg_q    <= 1'b0;
      nresp_q      <= '0;
      tx_data_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      key_valid_q  <= 1'b0;
      key_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      status_q     <= status_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      has_arg_q    <= has_arg_d;
      nresp_q      <= nresp_d;
      tx_data_q    <= tx_data_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      key_valid_q  <= key_valid_d;
      key_data_q   <= key_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    status_d     = status_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    has_arg_d    = has_arg_q;
    nresp_d      = nresp_q;
    tx_data_d    = tx_data_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    key_valid_d  = 1'b0;
    key_data_d   = key_data_q;

    case (state_q)
      IDLE: begin
        // Unsolicited bytes are forwarded even when a command starts in the same cycle.
        if (rx_valid) begin
          key_valid_d = 1'b1;
          key_data_d  = rx_data;
        end
        if (cmd_valid) begin
          cmd_d     = cmd_byte;
          arg_d     = cmd_arg;
          has_arg_d = cmd_has_arg;
          nresp_d   = cmd_nresp;
          phase_d   = PH_CMD;
          retry_d   = '0;
          tx_data_d = cmd_byte;
          state_d   = SEND;
        end
      end

      SEND: state_d = TXG;

      TXG:  state_d = TXW;

      TXW: begin
        if (!tx_active) begin
          if (tx_err) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = SEND;
            end else begin
              status_d = ST_TXERR;
              state_d  = FIN;
            end
          end else begin
            timer_d = TMO_LOAD;
            state_d = WACK;
          end
        end
      end

      WACK: begin
        if (rx_valid && rx_data == DEV_ACK) begin
          if (phase_q == PH_CMD && has_arg_q) begin
            phase_d   = PH_ARG;
            retry_d   = '0;
            tx_data_d = arg_q;
            state_d   = SEND;
          end else if (nresp_q == 2'd0) begin
            status_d = ST_OK;
            state_d  = FIN;
          end else begin
            timer_d = TMO_LOAD;
            state_d = WRSP;
          end
        end else if (rx_valid && rx_data == DEV_RESEND) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = SEND;
          end else begin
            status_d = ST_NAK;
            state_d  = FIN;
          end
        end else if (rx_valid && rx_data == DEV_ERROR) begin
          status_d = ST_NAK;
          state_d  = FIN;
        end else if (timer_q == '0) begin
          // Any other byte is ignored and does not stall the timeout.
          status_d = ST_TIMEOUT;
          state_d  = FIN;
        end else begin
          timer_d = timer_q - 19'd1;
        end
      end

      WRSP: begin
        if (rx_valid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = rx_data;
          timer_d      = TMO_LOAD;
          nresp_d      = nresp_q - 2'd1;
          if (nresp_q == 2'd1) begin
            status_d = ST_OK;
            state_d  = FIN;
          end
        end else if (timer_q == '0) begin
          status_d = ST_TIMEOUT;
          state_d  = FIN;
        end else begin
          timer_d = timer_q - 19'd1;
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Scoreboard bench for ps2_cmd_ctrl: directed commands push expected events,
// a negedge monitor pops and compares each strobe the DUT presents.
module tb_ps2_cmd_ctrl;

  localparam int unsigned TMO = 200;
  localparam int unsigned BOUND = 2000;

  localparam logic [1:0] EV_KEY  = 2'd0;
  localparam logic [1:0] EV_TX   = 2'd1;
  localparam logic [1:0] EV_RESP = 2'd2;
  localparam logic [1:0] EV_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_byte = '0;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] cmd_arg = '0;
  logic [1:0] cmd_nresp = '0;
  logic       done;
  logic [1:0] status;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       key_valid;
  logic [7:0] key_data;
  logic       tx_ena;
  logic [7:0] tx_data;
  logic       tx_active = 1'b0;
  logic       tx_err = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tx_cnt  = 0;
  ev_t  exp_q[$];

  ps2_cmd_ctrl #(.ACK_TIMEOUT(TMO), .MAX_RETRY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
    .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg), .cmd_nresp(cmd_nresp),
    .done(done), .status(status),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .key_valid(key_valid), .key_data(key_data),
    .tx_ena(tx_ena), .tx_data(tx_data), .tx_active(tx_active), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy for six cycles after each start pulse.
  always @(posedge clk) begin
    if (tx_ena) begin
      tx_active <= 1'b1;
      tx_cnt    <= 6;
    end else if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_active <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input string name, input logic [1:0] kind, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s: got data %0h, expected no event", name, data);
    end else begin
      e = exp_q.pop_front();
      check({name, "_kind"}, 32'(kind), 32'(e.kind));
      check({name, "_data"}, 32'(data), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid)  observe("key",  EV_KEY,  key_data);
      if (tx_ena)     observe("tx",   EV_TX,   tx_data);
      if (resp_valid) observe("resp", EV_RESP, resp_data);
      if (done)       observe("done", EV_DONE, {6'd0, status});
    end
  end

  task automatic issue_cmd(input logic [7:0] b, input logic has_arg, input logic [7:0] arg,
                           input logic [1:0] nresp, input logic with_rx, input logic [7:0] rxb);
    int k = 0;
    while (!cmd_ready && k < BOUND) begin @(negedge clk); k++; end
    if (k >= BOUND) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_byte    = b;
    cmd_has_arg = has_arg;
    cmd_arg     = arg;
    cmd_nresp   = nresp;
    rx_valid    = with_rx;
    rx_data     = rxb;
    @(negedge clk);
    cmd_valid = 1'b0;
    rx_valid  = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle();
    int k = 0;
    while (!tx_ena && k < BOUND) begin @(negedge clk); k++; end
    while (!tx_active && k < BOUND) begin @(negedge clk); k++; end
    while (tx_active && k < BOUND) begin @(negedge clk); k++; end
    if (k >= BOUND) check("tx_wait", 32'(k), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < BOUND) begin @(negedge clk); k++; end
    if (k >= BOUND) check("done_wait", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check("rst_tx_ena",     32'(tx_ena),     32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_status",     32'(status),     32'd0);
    check("rst_tx_data",    32'(tx_data),    32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data",  32'(resp_data),  32'd0);
    check("rst_key_valid",  32'(key_valid),  32'd0);
    check("rst_key_data",   32'(key_data),   32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Enable reporting; rx during transmit dropped, unknown byte in WACK ignored.
    expect_ev(EV_TX, 8'hF4);
    expect_ev(EV_DONE, 8'd0);
    issue_cmd(8'hF4, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
    k = 0;
    while (!tx_active && k < 20) begin @(negedge clk); k++; end
    send_rx(8'h33);
    while (tx_active && k < 40) begin @(negedge clk); k++; end
    @(negedge clk);
    send_rx(8'h55);
    send_rx(8'hFA);
    wait_done();

    // Unsolicited byte while idle.
    expect_ev(EV_KEY, 8'h5A);
    send_rx(8'h5A);
    repeat (2) @(negedge clk);

    // Command with argument.
    expect_ev(EV_TX, 8'hED);
    expect_ev(EV_TX, 8'h07);
    expect_ev(EV_DONE, 8'd0);
    issue_cmd(8'hED, 1'b1, 8'h07, 2'd0, 1'b0, 8'h00);
    wait_tx_idle();
    send_rx(8'hFA);
    wait_tx_idle();
    send_rx(8'hFA);
    wait_done();

    // Reset command with one response byte.
    expect_ev(EV_TX, 8'hFF);
    expect_ev(EV_RESP, 8'hAA);
    expect_ev(EV_DONE, 8'd0);
    issue_cmd(8'hFF, 1'b0, 8'h00, 2'd1, 1'b0, 8'h00);
    wait_tx_idle();
    send_rx(8'hFA);
    send_rx(8'hAA);
    wait_done();
    repeat (3) @(negedge clk);
    check("resp_data_hold", 32'(resp_data), 32'hAA);

    // Four RESENDs exhaust three retries.
    for (int i = 0; i < 4; i++) expect_ev(EV_TX, 8'hF4);
    expect_ev(EV_DONE, 8'd2);
    issue_cmd(8'hF4, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      wait_tx_idle();
      send_rx(8'hFE);
    end
    wait_done();
    repeat (3) @(negedge clk);
    check("status_hold", 32'(status), 32'd2);

    // Device ERROR ends immediately with NAK.
    expect_ev(EV_TX, 8'hF5);
    expect_ev(EV_DONE, 8'd2);
    issue_cmd(8'hF5, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
    wait_tx_idle();
    send_rx(8'hFC);
    wait_done();

    // Silent device: TIMEOUT exactly TMO cycles after WACK entry.
    expect_ev(EV_TX, 8'hF4);
    expect_ev(EV_DONE, 8'd1);
    issue_cmd(8'hF4, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
    k = 0;
    while (!tx_active && k < 20) begin @(negedge clk); k++; end
    while (tx_active && k < 40) begin @(negedge clk); k++; end
    // WACK is entered one cycle after the transmitter reports idle.
    k = 0;
    while (!done && k < BOUND) begin @(negedge clk); k++; end
    check("timeout_cycles", 32'(k), 32'(TMO + 1));
    @(negedge clk);

    // Transmitter error on every attempt.
    tx_err = 1'b1;
    for (int i = 0; i < 4; i++) expect_ev(EV_TX, 8'hF3);
    expect_ev(EV_DONE, 8'd3);
    issue_cmd(8'hF3, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
    wait_done();
    tx_err = 1'b0;

    // Key byte arriving with cmd_valid in the same cycle.
    expect_ev(EV_KEY, 8'h1C);
    expect_ev(EV_TX, 8'hF4);
    expect_ev(EV_DONE, 8'd0);
    issue_cmd(8'hF4, 1'b0, 8'h00, 2'd0, 1'b1, 8'h1C);
    wait_tx_idle();
    send_rx(8'hFA);
    wait_done();
    check("key_data_hold", 32'(key_data), 32'h1C);

    // Reset while waiting for ACK aborts without done.
    expect_ev(EV_TX, 8'hF4);
    issue_cmd(8'hF4, 1'b0, 8'h00, 2'd0, 1'b0, 8'h00);
    wait_tx_idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_done",      32'(done),      32'd0);
    check("abort_status",    32'(status),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (TMO + 20) @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
